led_blink_multi: RTL and testbench



---
 rtl/led_blink_multi.sv | 152 +++++++++++++++
 tb/tb_led_blink_multi.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/led_blink_multi.sv
// led_blink_multi: multi-channel LED blinker with a shared 1 kHz timebase.
// A prescaler divides clk down to a one-cycle tick; each channel runs off,
// solid-on, blink or burst mode at its own programmable half-period.
// Optional feature macro: LED_BLINK_MULTI_BURST_EN (burst mode 11). When it
// is undefined, mode 11 behaves as blink and no burst state is built.
module led_blink_multi #(
  parameter int unsigned CLK_HZ     = 2_080_000,
  parameter int unsigned TICK_HZ    = 1_000,
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned HP_W       = 16,
  parameter int unsigned DEFAULT_HP = 500,
  parameter int unsigned BURST_N    = 3,
  parameter int unsigned BURST_GAP  = 4,
  localparam int unsigned CHW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [CHW-1:0]    wr_ch,
  input  logic [1:0]        wr_mode,
  input  logic [HP_W-1:0]   wr_hp,
  output logic              tick,
  output logic [NUM_CH-1:0] led
);

  localparam int unsigned PRESCALE = CLK_HZ / TICK_HZ;
  localparam int unsigned PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_ON    = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_BURST = 2'b11
  } mode_e;

  // Parameter sanity: an unusable configuration stops elaboration.
  if (PRESCALE < 2 || PRESCALE * TICK_HZ != CLK_HZ || NUM_CH < 1 || NUM_CH > 16 ||
      BURST_N < 1 || (2 * BURST_N + BURST_GAP) < 2 || HP_W < 1) begin : g_cfg_err
    $error("led_blink_multi: invalid parameter set");
  end

  logic [PW-1:0]   pcnt_q, pcnt_d;
  mode_e           mode_q [NUM_CH];
  mode_e           mode_d [NUM_CH];
  logic [HP_W-1:0] hp_q   [NUM_CH];
  logic [HP_W-1:0] hp_d   [NUM_CH];
  logic [HP_W-1:0] tcnt_q [NUM_CH];
  logic [HP_W-1:0] tcnt_d [NUM_CH];
  logic [NUM_CH-1:0] led_q, led_d;
  logic            wr_hit;

`ifdef LED_BLINK_MULTI_BURST_EN
  localparam int unsigned BP = 2 * BURST_N + BURST_GAP;
  localparam int unsigned UW = $clog2(BP);
  logic [UW-1:0]   u_q [NUM_CH];
  logic [UW-1:0]   u_d [NUM_CH];
`endif

  // A programmed half-period of 0 runs as 1.
  function automatic logic [HP_W-1:0] eff_hp(input logic [HP_W-1:0] hp);
    return (hp == '0) ? HP_W'(1) : hp;
  endfunction

  assign tick   = (pcnt_q == PW'(PRESCALE - 1));
  assign led    = led_q;
  assign wr_hit = wr_en && (32'(wr_ch) < NUM_CH);

  // Next-state for the prescaler and every channel; a write overrides the tick.
  always_comb begin
    pcnt_d = tick ? '0 : pcnt_q + PW'(1);
    led_d  = led_q;
    for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
      mode_d[ch] = mode_q[ch];
      hp_d[ch]   = hp_q[ch];
      tcnt_d[ch] = tcnt_q[ch];
`ifdef LED_BLINK_MULTI_BURST_EN
      u_d[ch]    = u_q[ch];
`endif
      unique case (mode_q[ch])
        MODE_OFF: begin
          tcnt_d[ch] = '0;
          led_d[ch]  = 1'b0;
`ifdef LED_BLINK_MULTI_BURST_EN
          u_d[ch]    = '0;
`endif
        end
        MODE_ON: begin
          tcnt_d[ch] = '0;
          led_d[ch]  = 1'b1;
`ifdef LED_BLINK_MULTI_BURST_EN
          u_d[ch]    = '0;
`endif
        end
        MODE_BLINK, MODE_BURST: begin
          if (tick) begin
            if (tcnt_q[ch] == eff_hp(hp_q[ch]) - HP_W'(1)) begin
              tcnt_d[ch] = '0;
`ifdef LED_BLINK_MULTI_BURST_EN
              if (mode_q[ch] == MODE_BURST) begin
                u_d[ch]   = (u_q[ch] == UW'(BP - 1)) ? '0 : u_q[ch] + UW'(1);
                led_d[ch] = u_d[ch][0] && (32'(u_d[ch]) < 2 * BURST_N);
              end else begin
                led_d[ch] = ~led_q[ch];
              end
`else
              led_d[ch]  = ~led_q[ch];
`endif
            end else begin
              tcnt_d[ch] = tcnt_q[ch] + HP_W'(1);
            end
          end
        end
        default: ;
      endcase
      if (wr_hit && (32'(wr_ch) == ch)) begin
        mode_d[ch] = mode_e'(wr_mode);
        hp_d[ch]   = wr_hp;
        tcnt_d[ch] = '0;
        led_d[ch]  = (mode_e'(wr_mode) == MODE_ON);
`ifdef LED_BLINK_MULTI_BURST_EN
        u_d[ch]    = '0;
`endif
      end
    end
  end

  // State registers; power-on state is every channel blinking at DEFAULT_HP.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pcnt_q <= '0;
      led_q  <= '0;
      for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
        mode_q[ch] <= MODE_BLINK;
        hp_q[ch]   <= HP_W'(DEFAULT_HP);
        tcnt_q[ch] <= '0;
`ifdef LED_BLINK_MULTI_BURST_EN
        u_q[ch]    <= '0;
`endif
      end
    end else begin
      pcnt_q <= pcnt_d;
      led_q  <= led_d;
      mode_q <= mode_d;
      hp_q   <= hp_d;
      tcnt_q <= tcnt_d;
`ifdef LED_BLINK_MULTI_BURST_EN
      u_q    <= u_d;
`endif
    end
  end

endmodule

// File: tb/tb_led_blink_multi.sv
// tb_led_blink_multi: self-checking bench for led_blink_multi.
// Reference model: per channel, counts ticks seen since the last phase
// restart and derives the LED from the number of whole half-periods elapsed.
module tb_led_blink_multi;

  localparam int unsigned CLK_HZ     = 1000;
  localparam int unsigned TICK_HZ    = 100;
  localparam int unsigned NUM_CH     = 4;
  localparam int unsigned HP_W       = 16;
  localparam int unsigned DEFAULT_HP = 3;
  localparam int unsigned BURST_N    = 2;
  localparam int unsigned BURST_GAP  = 3;
  localparam int unsigned PS         = CLK_HZ / TICK_HZ;
  localparam int unsigned PER        = 2 * BURST_N + BURST_GAP;
  localparam int unsigned CHW        = 2;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              wr_en = 1'b0;
  logic [CHW-1:0]    wr_ch = '0;
  logic [1:0]        wr_mode = '0;
  logic [HP_W-1:0]   wr_hp = '0;
  logic              tick;
  logic [NUM_CH-1:0] led;

  int total = 0;
  int bad   = 0;

  int unsigned edge_no;
  int unsigned m_mode [NUM_CH];
  int unsigned m_hp   [NUM_CH];
  int unsigned m_n    [NUM_CH];

  always #5 clk = ~clk;

  led_blink_multi #(
    .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .NUM_CH(NUM_CH), .HP_W(HP_W),
    .DEFAULT_HP(DEFAULT_HP), .BURST_N(BURST_N), .BURST_GAP(BURST_GAP)
  ) dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_ch(wr_ch),
    .wr_mode(wr_mode), .wr_hp(wr_hp), .tick(tick), .led(led)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s edge=%0d got=%0h exp=%0h", tag, edge_no, got, exp);
    end
  endtask

  function automatic logic exp_led(input int unsigned ch);
    int unsigned hpe, e, u;
    hpe = (m_hp[ch] == 0) ? 1 : m_hp[ch];
    e   = m_n[ch] / hpe;
    u   = e % PER;
    case (m_mode[ch])
      0: return 1'b0;
      1: return 1'b1;
`ifdef LED_BLINK_MULTI_BURST_EN
      3: return (u % 2 == 1) && (u < 2 * BURST_N);
`endif
      default: return (e % 2) == 1;
    endcase
  endfunction

  function automatic logic [NUM_CH-1:0] exp_leds();
    logic [NUM_CH-1:0] v;
    for (int unsigned ch = 0; ch < NUM_CH; ch++) v[ch] = exp_led(ch);
    return v;
  endfunction

  task automatic model_reset();
    edge_no = 0;
    for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
      m_mode[ch] = 2;
      m_hp[ch]   = DEFAULT_HP;
      m_n[ch]    = 0;
    end
  endtask

  // Applies the inputs present at this rising edge to the model.
  task automatic model_edge();
    edge_no++;
    for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
      if (wr_en && (int'(wr_ch) < NUM_CH) && (int'(wr_ch) == ch)) begin
        m_mode[ch] = int'(wr_mode);
        m_hp[ch]   = int'(wr_hp);
        m_n[ch]    = 0;
      end else if (edge_no % PS == 0) begin
        m_n[ch]++;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("led", 32'(led), 32'(exp_leds()));
    check_eq("tick", 32'(tick), 32'((edge_no % PS) == PS - 1));
  endtask

  task automatic do_write(input int unsigned ch, input int unsigned mode, input int unsigned hp);
    wr_en   = 1'b1;
    wr_ch   = CHW'(ch);
    wr_mode = 2'(mode);
    wr_hp   = HP_W'(hp);
    step();
    wr_en   = 1'b0;
  endtask

  task automatic run_to(input int unsigned e);
    while (edge_no < e) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog edge=%0d got=running exp=finished", edge_no);
    $fatal(1);
  end

  initial begin
    model_reset();
    #12;
    check_eq("rst_led", 32'(led), 32'(0));
    check_eq("rst_tick", 32'(tick), 32'(0));
    reset_n = 1'b1;

    // Power-on default blinking.
    while (edge_no < 99) begin
      step();
      if (edge_no == 30) check_eq("rise30", 32'(led), 32'hF);
      if (edge_no == 60) check_eq("fall60", 32'(led), 32'h0);
      if (edge_no == 90) check_eq("rise90", 32'(led), 32'hF);
    end

    // Asynchronous reset with tick and LEDs high.
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("arst_led", 32'(led), 32'(0));
    check_eq("arst_tick", 32'(tick), 32'(0));
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();

    // Mode writes: burst on ch3, off/on/blink on ch1/ch2/ch0.
    step();
    do_write(3, 3, 1);
    do_write(1, 0, 7);
    do_write(2, 1, 9);
    check_eq("on_ch2", 32'(led[2]), 32'(1));
    do_write(0, 2, 1);
    while (edge_no < 39) begin
      step();
      if (edge_no == 10) check_eq("ch0_t10", 32'(led[0]), 32'(1));
      if (edge_no == 20) check_eq("ch0_t20", 32'(led[0]), 32'(0));
      if (edge_no == 30) check_eq("ch0_t30", 32'(led[0]), 32'(1));
      if (edge_no == 10) check_eq("ch3_t10", 32'(led[3]), 32'(1));
    end
    // Write on the tick edge with hp=0: phase restarts, tick not counted.
    do_write(0, 2, 0);
    check_eq("tickwr_ch0", 32'(led[0]), 32'(0));
    while (edge_no < 140) begin
      step();
      if (edge_no == 49) check_eq("tickwr_49", 32'(led[0]), 32'(0));
      if (edge_no == 50) check_eq("tickwr_50", 32'(led[0]), 32'(1));
`ifdef LED_BLINK_MULTI_BURST_EN
      if (edge_no == 50) check_eq("burst_50", 32'(led[3]), 32'(0));
      if (edge_no == 80) check_eq("burst_80", 32'(led[3]), 32'(1));
`else
      if (edge_no == 50) check_eq("burst_50", 32'(led[3]), 32'(1));
      if (edge_no == 80) check_eq("burst_80", 32'(led[3]), 32'(0));
`endif
      if (edge_no == 40) check_eq("ch1_off", 32'(led[1]), 32'(0));
    end

    // Randomized writes against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        int unsigned r;
        r = $urandom_range(0, 9);
        do_write($urandom_range(0, NUM_CH - 1), $urandom_range(0, 3),
                 (r < 8) ? (r % 4) : $urandom_range(0, 12));
      end else begin
        step();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
